// File: rtl/geometry_buffer.sv
// geometry_buffer: screen-space vertex store, one write port, three read ports.
// Optional zero-fill sweep on reset release when GBUFFER_CLEAR_EN is defined.
module geometry_buffer #(
    parameter  int VERTEX_DATAWIDTH = 12,
    parameter  int MAX_VERTEX_COUNT = 16384,
    localparam int AW = $clog2(MAX_VERTEX_COUNT),
    localparam int DW = 3 * VERTEX_DATAWIDTH
) (
    input  logic          clk,
    input  logic          rstn,
    output logic          ready,
    input  logic          write_en,
    input  logic          read_en,
    input  logic [AW-1:0] addr_write,
    input  logic [AW-1:0] addr_read_port0,
    input  logic [AW-1:0] addr_read_port1,
    input  logic [AW-1:0] addr_read_port2,
    input  logic [DW-1:0] data_write,
    output logic [DW-1:0] data_read_port0,
    output logic [DW-1:0] data_read_port1,
    output logic [DW-1:0] data_read_port2,
    output logic          dv
);

    localparam logic [AW:0] MAX_W = (AW + 1)'(MAX_VERTEX_COUNT);

    // Synthesis replicates this array once per read port.
    logic [DW-1:0] mem [MAX_VERTEX_COUNT];

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_active;
    logic          rd_fire;

    logic          dv_q, dv_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic [DW-1:0] rd2_q, rd2_d;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < MAX_W;
    endfunction

`ifdef GBUFFER_CLEAR_EN
    typedef enum logic {S_CLEAR, S_READY} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    // Clear sequencer state; reset always restarts the sweep at address 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Walk every address once, then hand the buffer over to the pipeline.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == S_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == AW'(MAX_VERTEX_COUNT - 1))
                state_d = S_READY;
        end
    end

    assign ready      = (state_q == S_READY);
    assign clr_active = (state_q == S_CLEAR);
`else
    logic ready_q, ready_d;

    // Ready rises on the first edge after reset release and stays high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_q <= 1'b0;
        else       ready_q <= ready_d;
    end

    assign ready_d    = 1'b1;
    assign ready      = ready_q;
    assign clr_active = 1'b0;
`endif

    assign rd_fire = read_en & ready;

    // Write port mux: the clear sweep owns the port until ready.
    always_comb begin
        wr_en   = clr_active | (write_en & ready & in_range(addr_write));
        wr_addr = addr_write;
        wr_data = data_write;
`ifdef GBUFFER_CLEAR_EN
        if (clr_active) begin
            wr_addr = clr_addr_q;
            wr_data = '0;
        end
`endif
    end

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-first lookup; out-of-range ports return zero, idle ports hold.
    always_comb begin
        dv_d  = rd_fire;
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (rd_fire) begin
            rd0_d = in_range(addr_read_port0) ? mem[addr_read_port0] : '0;
            rd1_d = in_range(addr_read_port1) ? mem[addr_read_port1] : '0;
            rd2_d = in_range(addr_read_port2) ? mem[addr_read_port2] : '0;
        end
    end

    // Output registers; reset discards any read in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_q  <= 1'b0;
            rd0_q <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            dv_q  <= dv_d;
            rd0_q <= rd0_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign dv              = dv_q;
    assign data_read_port0 = rd0_q;
    assign data_read_port1 = rd1_q;
    assign data_read_port2 = rd2_q;

endmodule

// File: tb/tb_geometry_buffer.sv
// tb_geometry_buffer: directed checks for geometry_buffer.
// Uses MAX_VERTEX_COUNT=12 so out-of-range addresses are reachable.
module tb_geometry_buffer;

    localparam int VDW = 12;
    localparam int MAXV = 12;
    localparam int AW = $clog2(MAXV);
    localparam int DW = 3 * VDW;

    logic          clk;
    logic          rstn;
    logic          ready;
    logic          write_en;
    logic          read_en;
    logic [AW-1:0] addr_write;
    logic [AW-1:0] addr_read_port0;
    logic [AW-1:0] addr_read_port1;
    logic [AW-1:0] addr_read_port2;
    logic [DW-1:0] data_write;
    logic [DW-1:0] data_read_port0;
    logic [DW-1:0] data_read_port1;
    logic [DW-1:0] data_read_port2;
    logic          dv;

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] V0 = 36'h001002003;
    localparam logic [DW-1:0] V1 = 36'hABCDEF012;
    localparam logic [DW-1:0] V2 = 36'h7FF800FFF;

    geometry_buffer #(
        .VERTEX_DATAWIDTH(VDW),
        .MAX_VERTEX_COUNT(MAXV)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .ready(ready),
        .write_en(write_en),
        .read_en(read_en),
        .addr_write(addr_write),
        .addr_read_port0(addr_read_port0),
        .addr_read_port1(addr_read_port1),
        .addr_read_port2(addr_read_port2),
        .data_write(data_write),
        .data_read_port0(data_read_port0),
        .data_read_port1(data_read_port1),
        .data_read_port2(data_read_port2),
        .dv(dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        int n;
        int exp_n;
`ifdef GBUFFER_CLEAR_EN
        exp_n = MAXV;
`else
        exp_n = 1;
`endif
        n = 0;
        rstn = 1'b1;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n != exp_n || ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_latency got %0d cycles ready=%b want %0d",
                     n, ready, exp_n);
        end
    endtask

    task automatic test_reset();
        write_en = 0; read_en = 0;
        addr_write = '0; data_write = '0;
        addr_read_port0 = '0; addr_read_port1 = '0; addr_read_port2 = '0;
        rstn = 1'b0;
        #23;
        read_en = 1'b1;
        write_en = 1'b1;
        step();
        checks++;
        if (ready !== 1'b0 || dv !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ready=%b dv=%b want 0 0", ready, dv);
        end
        checks++;
        if (data_read_port0 !== '0 || data_read_port1 !== '0 ||
            data_read_port2 !== '0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0",
                     data_read_port0, data_read_port1, data_read_port2);
        end
        read_en = 1'b0;
        write_en = 1'b0;
        #3;
        release_reset();
        checks++;
        if (dv !== 1'b0) begin
            errors++;
            $display("FAIL reset_dv_after_release got %b want 0", dv);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en = 1'b1;
        addr_write = a;
        data_write = d;
        step();
        write_en = 1'b0;
    endtask

    task automatic test_write_read();
        wr(0, V0);
        wr(1, V1);
        wr(2, V2);
        read_en = 1'b1;
        addr_read_port0 = 0; addr_read_port1 = 1; addr_read_port2 = 2;
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== V0 ||
            data_read_port1 !== V1 || data_read_port2 !== V2) begin
            errors++;
            $display("FAIL basic_read dv=%b got %h %h %h want 1 %h %h %h",
                     dv, data_read_port0, data_read_port1, data_read_port2,
                     V0, V1, V2);
        end
        step();
        checks++;
        if (dv !== 1'b0 || data_read_port0 !== V0 ||
            data_read_port1 !== V1 || data_read_port2 !== V2) begin
            errors++;
            $display("FAIL idle_hold dv=%b got %h %h %h want 0 %h %h %h",
                     dv, data_read_port0, data_read_port1, data_read_port2,
                     V0, V1, V2);
        end
    endtask

    task automatic test_same_addr();
        read_en = 1'b1;
        addr_read_port0 = 1; addr_read_port1 = 1; addr_read_port2 = 1;
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== V1 ||
            data_read_port1 !== V1 || data_read_port2 !== V1) begin
            errors++;
            $display("FAIL same_addr dv=%b got %h %h %h want 1 %h x3",
                     dv, data_read_port0, data_read_port1, data_read_port2, V1);
        end
        step();
        checks++;
        if (dv !== 1'b0) begin
            errors++;
            $display("FAIL same_addr_dv_pulse got %b want 0", dv);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp [3];
        exp[0] = V0; exp[1] = V1; exp[2] = V2;
        addr_read_port1 = 2; addr_read_port2 = 0;
        for (int i = 0; i < 3; i++) begin
            read_en = 1'b1;
            addr_read_port0 = AW'(i);
            step();
            checks++;
            if (dv !== 1'b1 || data_read_port0 !== exp[i]) begin
                errors++;
                $display("FAIL pipe_%0d dv=%b got %h want 1 %h",
                         i, dv, data_read_port0, exp[i]);
            end
        end
        read_en = 1'b0;
        step();
        checks++;
        if (dv !== 1'b0 || data_read_port0 !== V2) begin
            errors++;
            $display("FAIL pipe_end dv=%b got %h want 0 %h",
                     dv, data_read_port0, V2);
        end
    endtask

    task automatic test_collision();
        wr(5, 36'h111111111);
        write_en = 1'b1;
        addr_write = 5;
        data_write = 36'h222222222;
        read_en = 1'b1;
        addr_read_port0 = 5; addr_read_port1 = 5; addr_read_port2 = 0;
        step();
        write_en = 1'b0;
        checks++;
        if (data_read_port0 !== 36'h111111111 ||
            data_read_port1 !== 36'h111111111) begin
            errors++;
            $display("FAIL collision_old got %h %h want 111111111",
                     data_read_port0, data_read_port1);
        end
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== 36'h222222222) begin
            errors++;
            $display("FAIL collision_new dv=%b got %h want 1 222222222",
                     dv, data_read_port0);
        end
    endtask

    task automatic test_write_read_diff();
        write_en = 1'b1;
        addr_write = 7;
        data_write = 36'h0A50C3F96;
        read_en = 1'b1;
        addr_read_port0 = 1; addr_read_port1 = 2; addr_read_port2 = 0;
        step();
        write_en = 1'b0;
        addr_read_port0 = 7;
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== 36'h0A50C3F96 ||
            data_read_port1 !== V2 || data_read_port2 !== V0) begin
            errors++;
            $display("FAIL diff_addr dv=%b got %h %h %h want 1 0a50c3f96 %h %h",
                     dv, data_read_port0, data_read_port1, data_read_port2,
                     V2, V0);
        end
    endtask

    task automatic test_out_of_range();
        wr(13, 36'h123456789);
        wr(15, 36'h987654321);
        read_en = 1'b1;
        addr_read_port0 = 13; addr_read_port1 = 0; addr_read_port2 = 15;
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== '0 ||
            data_read_port1 !== V0 || data_read_port2 !== '0) begin
            errors++;
            $display("FAIL out_of_range dv=%b got %h %h %h want 1 0 %h 0",
                     dv, data_read_port0, data_read_port1, data_read_port2, V0);
        end
        read_en = 1'b1;
        addr_read_port0 = 2; addr_read_port1 = 1; addr_read_port2 = 0;
        step();
        read_en = 1'b0;
        checks++;
        if (data_read_port0 !== V2 || data_read_port1 !== V1 ||
            data_read_port2 !== V0) begin
            errors++;
            $display("FAIL oor_no_alias got %h %h %h want %h %h %h",
                     data_read_port0, data_read_port1, data_read_port2,
                     V2, V1, V0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] exp0;
`ifdef GBUFFER_CLEAR_EN
        exp0 = '0;
`else
        exp0 = V1;
`endif
        read_en = 1'b1;
        addr_read_port0 = 1; addr_read_port1 = 2; addr_read_port2 = 0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b0 || data_read_port0 !== '0 ||
            data_read_port1 !== '0 || data_read_port2 !== '0) begin
            errors++;
            $display("FAIL mid_reset dv=%b got %h %h %h want 0 0 0 0",
                     dv, data_read_port0, data_read_port1, data_read_port2);
        end
        step();
        #2;
        release_reset();
        step();
        checks++;
        if (dv !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_dv_idle got %b want 0", dv);
        end
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== exp0) begin
            errors++;
            $display("FAIL post_reset_read dv=%b got %h want 1 %h",
                     dv, data_read_port0, exp0);
        end
    endtask

`ifdef GBUFFER_CLEAR_EN
    task automatic test_clear();
        int n;
        rstn = 1'b0;
        #7;
        rstn = 1'b1;
        write_en = 1'b1;
        addr_write = 3;
        data_write = 36'hFFFFFFFFF;
        read_en = 1'b1;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        write_en = 1'b0;
        read_en = 1'b0;
        checks++;
        if (n != MAXV || dv !== 1'b0) begin
            errors++;
            $display("FAIL clear_sweep cycles=%0d dv=%b want %0d 0",
                     n, dv, MAXV);
        end
        read_en = 1'b1;
        addr_read_port0 = 3; addr_read_port1 = 11; addr_read_port2 = 1;
        step();
        read_en = 1'b0;
        checks++;
        if (dv !== 1'b1 || data_read_port0 !== '0 ||
            data_read_port1 !== '0 || data_read_port2 !== '0) begin
            errors++;
            $display("FAIL clear_contents dv=%b got %h %h %h want 1 0 0 0",
                     dv, data_read_port0, data_read_port1, data_read_port2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_same_addr();
        test_back_to_back();
        test_collision();
        test_write_read_diff();
        test_out_of_range();
        test_reset_mid_read();
`ifdef GBUFFER_CLEAR_EN
        test_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
